// File: rtl/rv_fetch_buf_pkg.sv
// rv_fetch_buf_pkg
//   Shared fetch/decode types.
//   ucode_t    : bus presented to decode {pc, pc_p4, instr}.
//   fb_entry_t : one buffered fetch entry {instr, pc, pc_p4}; also intended
//                for the compressed-instruction expander.
//   fb_to_ucode: repacks a buffered entry into the decode bus layout.
package rv_fetch_buf_pkg;

  typedef struct packed {
    logic [31:2] pc;
    logic [31:2] pc_p4;
    logic [31:0] instr;
  } ucode_t;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:2] pc;
    logic [31:2] pc_p4;
  } fb_entry_t;

  function automatic ucode_t fb_to_ucode(input fb_entry_t e);
    ucode_t u;
    u.pc    = e.pc;
    u.pc_p4 = e.pc_p4;
    u.instr = e.instr;
    return u;
  endfunction

endpackage

// File: rtl/rv_fifo_ctl.sv
// rv_fifo_ctl
//   Pointer / occupancy controller for a DEPTH-entry circular FIFO.
//   Ports:
//     clk_i     in  : clock
//     rst_ni    in  : synchronous active-low reset
//     flush_i   in  : clears pointers and count (same effect as reset)
//     push_i    in  : write one entry at wr_ptr_o (ignored when full)
//     pop_i     in  : retire the entry at rd_ptr_o (ignored when empty)
//     wr_ptr_o  out : next write slot
//     rd_ptr_o  out : current head slot
//     count_o   out : occupied entries
//     full_o    out : count_o == DEPTH
//     empty_o   out : count_o == 0
//   Occupancy is a separate counter rather than a pointer difference, so
//   full and empty are unambiguous without an extra wrap bit.
module rv_fifo_ctl
  import rv_fetch_buf_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int PTR_W = $clog2(DEPTH),
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             flush_i,
  input  logic             push_i,
  input  logic             pop_i,
  output logic [PTR_W-1:0] wr_ptr_o,
  output logic [PTR_W-1:0] rd_ptr_o,
  output logic [CNT_W-1:0] count_o,
  output logic             full_o,
  output logic             empty_o
);

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             push_ok, pop_ok;

  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);

  // Guard here as well so the block stays safe when reused by callers that
  // do not qualify their requests.
  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    // DEPTH is a power of two, so pointer overflow is the modulo wrap.
    if (push_ok) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop_ok)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    unique case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni || flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign wr_ptr_o = wr_ptr_q;
  assign rd_ptr_o = rd_ptr_q;
  assign count_o  = count_q;

endmodule

// File: rtl/rv_fetch_buf.sv
// rv_fetch_buf
//   DEPTH-entry instruction buffer between fetch and decode.
//   Ports:
//     i_clk      in  : clock
//     i_reset_n  in  : synchronous active-low reset
//     i_flush    in  : discard buffered and incoming entries
//     i_valid    in  : fetch offers {i_data, i_pc, i_pc_p4}
//     i_data     in  : instruction word
//     i_pc       in  : PC[31:2] of i_data
//     i_pc_p4    in  : PC+4[31:2] of i_data
//     o_ready    out : a push is accepted this cycle (not full)
//     i_stall    in  : decode holds the head
//     o_valid    out : o_bus carries a valid instruction
//     o_bus      out : registered head entry, '0 when not valid
//     o_count    out : occupied entries, head included
//   The array holds every occupied entry including the head; o_bus is a
//   registered copy of the head so decode never sees a combinational path
//   from fetch or from the array.
module rv_fetch_buf
  import rv_fetch_buf_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             i_clk,
  input  logic             i_reset_n,
  input  logic             i_flush,
  input  logic             i_valid,
  input  logic [31:0]      i_data,
  input  logic [31:2]      i_pc,
  input  logic [31:2]      i_pc_p4,
  output logic             o_ready,
  input  logic             i_stall,
  output logic             o_valid,
  output ucode_t           o_bus,
  output logic [CNT_W-1:0] o_count
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [PTR_W-1:0] wr_ptr, rd_ptr, rd_ptr_nxt;
  logic [CNT_W-1:0] count;
  logic             full, empty;
  logic             push, pop;

  fb_entry_t        in_entry;
  fb_entry_t        mem_q [DEPTH];

  logic             valid_q, valid_d;
  ucode_t           bus_q, bus_d;

  assign in_entry = '{instr: i_data, pc: i_pc, pc_p4: i_pc_p4};

  // o_ready comes only from registered occupancy, so a full buffer refuses
  // a push even in a cycle where decode pops.
  assign push = i_valid && !full && !i_flush;
  assign pop  = valid_q && !i_stall && !i_flush;

  rv_fifo_ctl #(
    .DEPTH (DEPTH),
    .PTR_W (PTR_W),
    .CNT_W (CNT_W)
  ) u_ctl (
    .clk_i    (i_clk),
    .rst_ni   (i_reset_n),
    .flush_i  (i_flush),
    .push_i   (push),
    .pop_i    (pop),
    .wr_ptr_o (wr_ptr),
    .rd_ptr_o (rd_ptr),
    .count_o  (count),
    .full_o   (full),
    .empty_o  (empty)
  );

  // Storage is not reset: occupancy decides which slots are meaningful.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot
    always_ff @(posedge i_clk) begin
      if (push && (wr_ptr == PTR_W'(gi))) begin
        mem_q[gi] <= in_entry;
      end
    end
  end

  assign rd_ptr_nxt = rd_ptr + PTR_W'(1);

  // Output register next state:
  //   pop with more than one entry  -> next array slot becomes head
  //   pop of the last entry + push  -> pushed entry becomes head (it is not
  //                                    in the array yet this cycle)
  //   pop of the last entry alone   -> bubble
  //   empty + push                  -> pushed entry becomes head
  //   otherwise (incl. stall)       -> hold bit-stable
  always_comb begin
    valid_d = valid_q;
    bus_d   = bus_q;
    if (pop) begin
      if (count > CNT_W'(1)) begin
        valid_d = 1'b1;
        bus_d   = fb_to_ucode(mem_q[rd_ptr_nxt]);
      end else if (push) begin
        valid_d = 1'b1;
        bus_d   = fb_to_ucode(in_entry);
      end else begin
        valid_d = 1'b0;
        bus_d   = '0;
      end
    end else if (empty && push) begin
      valid_d = 1'b1;
      bus_d   = fb_to_ucode(in_entry);
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset_n || i_flush) begin
      valid_q <= 1'b0;
      bus_q   <= '0;
    end else begin
      valid_q <= valid_d;
      bus_q   <= bus_d;
    end
  end

  assign o_ready = !full;
  assign o_valid = valid_q;
  assign o_bus   = bus_q;
  assign o_count = count;

endmodule

// File: tb/tb_rv_fetch_buf.sv
// tb_rv_fetch_buf
//   Scoreboarded bench for rv_fetch_buf. The driver issues one cycle of
//   stimulus per call and records accepted entries in an expected queue;
//   the monitor compares the DUT against that queue at each falling edge
//   and retires the head whenever decode would consume it.
module tb_rv_fetch_buf;
  import rv_fetch_buf_pkg::*;

  localparam int DEPTH = 4;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic             i_clk = 1'b0;
  logic             i_reset_n = 1'b0;
  logic             i_flush = 1'b0;
  logic             i_valid = 1'b0;
  logic             i_stall = 1'b0;
  logic [31:0]      i_data = '0;
  logic [31:2]      i_pc = '0;
  logic [31:2]      i_pc_p4 = '0;
  logic             o_ready;
  logic             o_valid;
  ucode_t           o_bus;
  logic [CNT_W-1:0] o_count;

  always #5 i_clk = ~i_clk;

  rv_fetch_buf #(.DEPTH(DEPTH)) dut (
    .i_clk     (i_clk),
    .i_reset_n (i_reset_n),
    .i_flush   (i_flush),
    .i_valid   (i_valid),
    .i_data    (i_data),
    .i_pc      (i_pc),
    .i_pc_p4   (i_pc_p4),
    .o_ready   (o_ready),
    .i_stall   (i_stall),
    .o_valid   (o_valid),
    .o_bus     (o_bus),
    .o_count   (o_count)
  );

  fb_entry_t exp_q[$];
  fb_entry_t cur;
  fb_entry_t pend_e;
  bit        pend   = 1'b0;
  bit        chk_en = 1'b0;
  int        n_checks = 0;
  int        n_pass   = 0;

  task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic fb_entry_t new_ent();
    fb_entry_t e;
    e.instr = $urandom;
    e.pc    = 30'($urandom);
    e.pc_p4 = e.pc + 30'd1;
    return e;
  endfunction

  // One clock of stimulus. An entry accepted last cycle has now been
  // captured by the DUT, so it joins the expected queue first; then the
  // acceptance of this cycle's offer is decided from the queue's fill level
  // (a full buffer refuses even if decode drains in the same cycle).
  task automatic cycle(input bit v, input bit st, input bit fl, input bit rst);
    @(posedge i_clk);
    #1;
    if (pend) begin
      exp_q.push_back(pend_e);
      pend = 1'b0;
    end
    i_valid   = v;
    i_stall   = st;
    i_flush   = fl;
    i_reset_n = !rst;
    i_data    = cur.instr;
    i_pc      = cur.pc;
    i_pc_p4   = cur.pc_p4;
    if (v && !fl && !rst && (exp_q.size() != DEPTH)) begin
      pend   = 1'b1;
      pend_e = cur;
      $display("push instr=%h pc=%h", cur.instr, cur.pc);
      cur = new_ent();
    end
  endtask

  always @(negedge i_clk) begin : monitor
    int          sz;
    logic [95:0] exp_bus;
    fb_entry_t   h;
    if (chk_en) begin
      sz = exp_q.size();
      exp_bus = '0;
      if (sz != 0) begin
        h = exp_q[0];
        exp_bus = {4'd0, h.pc, h.pc_p4, h.instr};
      end
      check("count", 96'(o_count), 96'(sz));
      check("ready", 96'(o_ready), 96'(sz != DEPTH));
      check("valid", 96'(o_valid), 96'(sz != 0));
      check("bus",   96'(o_bus),   exp_bus);
      if (!i_reset_n || i_flush) begin
        exp_q.delete();
      end else if (sz != 0 && !i_stall) begin
        h = exp_q.pop_front();
        $display("pop  instr=%h pc=%h", h.instr, h.pc);
      end
    end
  end

  initial begin
    cur = new_ent();
    // Reset for two edges; checking starts once the first reset edge is in.
    cycle(0, 0, 0, 1);
    chk_en = 1'b1;
    cycle(0, 0, 0, 1);
    cycle(0, 0, 0, 0);

    // Single push after reset.
    cur = '{instr: 32'h00500093, pc: 30'h40, pc_p4: 30'h41};
    cycle(1, 0, 0, 0);
    repeat (3) cycle(0, 0, 0, 0);

    // Eight back-to-back pushes without stall.
    repeat (8) cycle(1, 0, 0, 0);
    repeat (3) cycle(0, 0, 0, 0);

    // Stall with continuous pushes: fills, fifth offer is held.
    repeat (6) cycle(1, 1, 0, 0);
    // Release while full with an offer pending: refused this cycle.
    cycle(1, 0, 0, 0);
    cycle(1, 0, 0, 0);
    repeat (6) cycle(0, 0, 0, 0);

    // Flush with three entries and a simultaneous push.
    repeat (3) cycle(1, 1, 0, 0);
    cycle(1, 1, 1, 0);
    repeat (2) cycle(0, 0, 0, 0);
    repeat (2) cycle(1, 0, 0, 0);
    repeat (3) cycle(0, 0, 0, 0);

    // Reset mid-drain with two entries left.
    repeat (3) cycle(1, 1, 0, 0);
    cycle(0, 0, 0, 0);
    cycle(0, 0, 0, 1);
    cycle(1, 0, 0, 0);
    repeat (2) cycle(0, 0, 0, 0);
    // More than DEPTH pushes with an occasional stall to exercise wrap.
    for (int i = 0; i < 3 * DEPTH; i++) cycle(1, (i % 5) == 2, 0, 0);
    repeat (DEPTH + 2) cycle(0, 0, 0, 0);

    // Randomized traffic with phases of heavy and light decode stall.
    for (int i = 0; i < 2000; i++) begin
      cycle($urandom_range(99) < 70,
            $urandom_range(99) < (((i / 100) % 2 == 0) ? 20 : 70),
            $urandom_range(49) == 0,
            $urandom_range(79) == 0);
    end
    repeat (DEPTH + 2) cycle(0, 0, 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
